// File: rtl/clock_pkg.sv
// clock_pkg: field widths and wrap limits for the time-of-day fields.
// Shared by time_keeper, the clock controller and the display blocks.
package clock_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

endpackage

// File: rtl/time_keeper_tick_gen.sv
// tick_gen: prescaler dividing clk down to a 1 Hz tick plus a 50 % blink.
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   clear       - synchronous restart of the prescaler (and blink phase)
//   tick_1hz    - high for the one cycle where the prescaler is at CLK_HZ-1
//   blink       - registered 1 Hz square wave, high for the first half period
module tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick_1hz,
  output logic blink
);

  localparam int unsigned W = $clog2(CLK_HZ);
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);
  localparam logic [W-1:0] HALF = W'(CLK_HZ / 2);

  logic [W-1:0] div_cnt;
  logic [W-1:0] div_cnt_next;

  always_comb begin
    div_cnt_next = div_cnt + 1'b1;
    if (clear || div_cnt == LAST) begin
      div_cnt_next = '0;
    end
  end

  assign tick_1hz = (div_cnt == LAST);

  // blink is derived from the next count so it stays phase-aligned with
  // div_cnt, and a clear restarts it high together with the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      blink   <= 1'b1;
    end else begin
      div_cnt <= div_cnt_next;
      blink   <= (div_cnt_next < HALF);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: free-running hours/minutes/seconds counter driven by a 1 Hz
// tick, with a load port for setting the time.
// Ports:
//   clk, rst_n          - system clock, async active-low reset
//   time_count_en       - advance the time on each 1 Hz tick
//   load_en             - load strobe; hour_load/min_load captured, sec cleared
//   hour_load, min_load - load values, out-of-range values load as 0
//   hour, min, sec      - current time, registered
//   sec_tick            - one-cycle pulse with each counted second
//   day_wrap            - one-cycle pulse on 23:59:59 -> 00:00:00
//   blink               - 1 Hz 50 % duty square wave
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              time_count_en,
  input  logic              load_en,
  input  logic [HOUR_W-1:0] hour_load,
  input  logic [MIN_W-1:0]  min_load,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              blink
);

  logic tick_1hz;
  logic count;

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (load_en),
    .tick_1hz (tick_1hz),
    .blink    (blink)
  );

  // A load discards a coincident tick; the prescaler is cleared alongside.
  assign count = tick_1hz & time_count_en & ~load_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour     <= '0;
      min      <= '0;
      sec      <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      if (load_en) begin
        hour <= (hour_load > HOUR_MAX) ? '0 : hour_load;
        min  <= (min_load > MIN_MAX) ? '0 : min_load;
        sec  <= '0;
      end else if (count) begin
        sec_tick <= 1'b1;
        if (sec == SEC_MAX) begin
          sec <= '0;
          if (min == MIN_MAX) begin
            min <= '0;
            if (hour == HOUR_MAX) begin
              hour     <= '0;
              day_wrap <= 1'b1;
            end else begin
              hour <= hour + 1'b1;
            end
          end else begin
            min <= min + 1'b1;
          end
        end else begin
          sec <= sec + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Free-running time-of-day counter for the digital clock. It divides the system clock down to a 1 Hz tick and keeps hours, minutes and seconds in binary. It accepts `time_count_en` and `load_en` plus the hour and minute load values from the clock controller, and returns `hour`, `min` and `sec` to it. It also produces a free-running blink strobe and per-second and per-day event pulses for the display and chime logic.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency. The 1 Hz tick period is exactly `CLK_HZ` cycles. Legal range is `CLK_HZ` >= 2, and it must be even. The bench uses 10.
- `clk` in 1: system clock. One clock domain, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `time_count_en` in 1: when high, the time advances on each 1 Hz tick.
- `load_en` in 1: single-cycle load strobe.
- `hour_load` in 5: hour value captured on `load_en`.
- `min_load` in 6: minute value captured on `load_en`.
- `hour` out 5: current hour, 0..23, registered.
- `min` out 6: current minute, 0..59, registered.
- `sec` out 6: current second, 0..59, registered.
- `sec_tick` out 1: one-cycle pulse, high in the cycle `sec` takes a new counted value.
- `day_wrap` out 1: one-cycle pulse, high in the cycle the time rolls from 23:59:59 to 00:00:00.
- `blink` out 1: 1 Hz square wave at 50 % duty, used to flash the field being adjusted.

## Operation
- **Prescaler `div_cnt`.**
  - Width is `$clog2(CLK_HZ)`. It counts 0..`CLK_HZ-1` and wraps to 0.
  - It runs regardless of `time_count_en`.
  - Internal `tick_1hz` is high when `div_cnt == CLK_HZ-1`.
- **Counting.** When `tick_1hz & time_count_en & !load_en`:
  - `sec` increments.
  - When `sec` is 59 it goes to 0 and `min` increments.
  - When `min` is 59 it goes to 0 and `hour` increments.
  - When `hour` is 23 it goes to 0.
  - `sec_tick` is 1 in this cycle.
  - `day_wrap` is 1 only when the prior value was 23:59:59.
- **Load.** When `load_en` is high:
  - `hour <= hour_load`, `min <= min_load`, `sec <= 0`, `div_cnt <= 0`.
  - Out-of-range values are replaced by 0 (`hour_load` > 23 gives 0, `min_load` > 59 gives 0).
  - `sec_tick` and `day_wrap` stay 0 in that cycle.
- **Priority.** Load wins over a coincident tick, regardless of `time_count_en`. The tick is discarded, not deferred.
- **Count disabled.** When `time_count_en` is low, the time holds. `div_cnt` and `blink` keep running, and no pulses are generated.
- **Blink.** `blink` is registered as `(div_cnt_next < CLK_HZ/2)`, so a load restarts the blink phase high.
- **Arithmetic.** All fields are unsigned. Wrap comparisons are equality against constants, never overflow of the field width.

## Timing
- Reset values while `rst_n` is low, applied asynchronously: `hour` = 0, `min` = 0, `sec` = 0, `div_cnt` = 0, `sec_tick` = 0, `day_wrap` = 0, `blink` = 1.
- First tick after reset release arrives on the `CLK_HZ`-th rising edge.
- Load latency: the new value is visible on outputs the cycle after `load_en` is sampled. The next `sec_tick` follows exactly `CLK_HZ` cycles after the load edge.
- `sec_tick` and `day_wrap` are registered and aligned with the updated `sec`/`min`/`hour`. Width is exactly one cycle, never back-to-back.
- Reset mid-operation aborts everything. No partial carry survives.
- `load_en` held high for several cycles reloads every cycle and keeps `div_cnt` at 0.

## Structure
- Shared package `clock_pkg` holds:
  - Constants: `HOUR_MAX` = 23, `MIN_MAX` = 59, `SEC_MAX` = 59.
  - Widths: `HOUR_W` = 5, `MIN_W` = 6, `SEC_W` = 6.
  - These are also consumed by the controller and display blocks.
- One sub-module, `tick_gen`:
  - Parameter `CLK_HZ`; inputs `clk`, `rst_n`, `clear`.
  - Outputs `tick_1hz` and `blink`.
  - Holds the prescaler. `time_keeper` instantiates it with `clear = load_en`.
- The H:M:S cascade lives in `time_keeper`.

## Test plan
- **Reset.** Assert `rst_n` = 0 asynchronously mid-run at 12:34:56 -> outputs go to 00:00:00 immediately, `blink` = 1, both pulses 0. They hold until release.
- **Count.** `CLK_HZ` = 10, `time_count_en` = 1 from reset -> `sec_tick` on cycles 10, 20, 30. `sec` reads 1, 2, 3, with `sec_tick` high exactly one cycle each.
- **Day rollover.** Load 23:59, count 59 seconds -> 23:59:59. The next tick gives 00:00:00 with `day_wrap` = 1 and `sec_tick` = 1 for one cycle.
- **Hold.** `time_count_en` = 0 for 50 cycles -> time is unchanged and `sec_tick` = 0. `blink` toggles every 5 cycles with period 10.
- **Load clamp and timing.**
  - `load_en` with `hour_load` = 24, `min_load` = 60 -> next cycle 00:00:00.
  - `load_en` with 12:34 -> next cycle 12:34:00.
- **Load/tick collision.** `load_en` in the same cycle as `tick_1hz` with `time_count_en` = 1 -> the loaded value appears with `sec` = 0 and no `sec_tick`. The next `sec_tick` comes 10 cycles later with `blink` restarted high.
